// File: rtl/l1d_miss_issue_scheduler_pkg.sv
// Shared types for the L1D miss-issue scheduler: entry state encoding and
// the per-entry record held in the scheduler's register file.
package l1d_sched_pkg;

    // Default geometry; the entry record's address field is sized from
    // LINE_ADDR_W_DEF, so the scheduler's LINE_ADDR_W must equal it.
    localparam int unsigned ENTRY_COUNT_DEF = 8;
    localparam int unsigned LINE_ADDR_W_DEF = 34;

    // Life cycle of a miss entry.
    typedef enum logic [1:0] {
        FREE       = 2'd0,
        WAIT_ISSUE = 2'd1,
        WAIT_RESP  = 2'd2
    } miss_state_e;

    // One miss entry: its state and the line it is fetching.
    typedef struct packed {
        miss_state_e                state;
        logic [LINE_ADDR_W_DEF-1:0] addr;
    } miss_entry_t;

endpackage

// File: rtl/l1d_miss_issue_scheduler_if.sv
// Bundle of the scheduler's allocation, memory-request, response, flush and
// status signals. The slave modport is the scheduler; master is its
// environment (L1D miss path plus the L2/bus port).
interface l1d_miss_issue_scheduler_if #(
    parameter int unsigned ENTRY_COUNT = l1d_sched_pkg::ENTRY_COUNT_DEF,
    parameter int unsigned LINE_ADDR_W = l1d_sched_pkg::LINE_ADDR_W_DEF
);
    localparam int unsigned TAG_W = $clog2(ENTRY_COUNT);

    // Allocation from the L1D miss path
    logic                   alloc_vld_i;
    logic [LINE_ADDR_W-1:0] alloc_addr_i;
    logic                   alloc_rdy_o;
    logic                   alloc_merge_o;
    logic [TAG_W-1:0]       alloc_tag_o;

    // Issue port towards L2 / bus
    logic                   mem_req_vld_o;
    logic                   mem_req_rdy_i;
    logic [LINE_ADDR_W-1:0] mem_req_addr_o;
    logic [TAG_W-1:0]       mem_req_tag_o;

    // Refill response
    logic                   mem_resp_vld_i;
    logic [TAG_W-1:0]       mem_resp_tag_i;

    // Control and status
    logic                   flush_i;
    logic [ENTRY_COUNT-1:0] busy_mask_o;
    logic                   full_o;
    logic                   empty_o;

    modport master (
        output alloc_vld_i, alloc_addr_i, mem_req_rdy_i,
               mem_resp_vld_i, mem_resp_tag_i, flush_i,
        input  alloc_rdy_o, alloc_merge_o, alloc_tag_o,
               mem_req_vld_o, mem_req_addr_o, mem_req_tag_o,
               busy_mask_o, full_o, empty_o
    );

    modport slave (
        input  alloc_vld_i, alloc_addr_i, mem_req_rdy_i,
               mem_resp_vld_i, mem_resp_tag_i, flush_i,
        output alloc_rdy_o, alloc_merge_o, alloc_tag_o,
               mem_req_vld_o, mem_req_addr_o, mem_req_tag_o,
               busy_mask_o, full_o, empty_o
    );

endinterface

// File: rtl/l1d_miss_issue_scheduler_age_matrix.sv
// Allocation-age matrix for the miss entries. Row i, bit j set means entry i
// was allocated after entry j (i is younger). Among any two busy entries
// exactly one direction is set, so every request mask has a unique oldest.
module l1d_miss_age_matrix
    import l1d_sched_pkg::*;
#(
    parameter  int unsigned ENTRY_COUNT = ENTRY_COUNT_DEF,
    localparam int unsigned TAG_W       = $clog2(ENTRY_COUNT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alloc_en_i,
    input  logic [TAG_W-1:0]       alloc_tag_i,
    input  logic [ENTRY_COUNT-1:0] busy_mask_i,
    input  logic [ENTRY_COUNT-1:0] free_mask_i,
    input  logic [ENTRY_COUNT-1:0] req_mask_i,
    output logic [ENTRY_COUNT-1:0] oldest_oh_o
);

    logic [ENTRY_COUNT-1:0] younger_q [ENTRY_COUNT];
    logic [ENTRY_COUNT-1:0] younger_d [ENTRY_COUNT];
    logic [ENTRY_COUNT-1:0] alloc_oh;
    logic [ENTRY_COUNT-1:0] survivor_mask;

    // One-hot of the entry being allocated this cycle (zero when none).
    always_comb begin
        alloc_oh = '0;
        if (alloc_en_i) begin
            alloc_oh[alloc_tag_i] = 1'b1;
        end
    end

    // Entries still busy after this cycle's frees; the new entry is younger than all of them.
    assign survivor_mask = busy_mask_i & ~free_mask_i & ~alloc_oh;

    // Next matrix: new row for the allocated entry, freed/allocated columns cleared.
    always_comb begin
        for (int i = 0; i < ENTRY_COUNT; i++) begin
            if (alloc_oh[i]) begin
                younger_d[i] = survivor_mask;
            end else begin
                younger_d[i] = younger_q[i] & ~free_mask_i & ~alloc_oh;
            end
        end
    end

    // Matrix registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRY_COUNT; i++) begin
                younger_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRY_COUNT; i++) begin
                younger_q[i] <= younger_d[i];
            end
        end
    end

    // An entry is oldest when it requests and is younger than no other requester.
    for (genvar gi = 0; gi < ENTRY_COUNT; gi++) begin : g_oldest
        assign oldest_oh_o[gi] = req_mask_i[gi] & ~|(younger_q[gi] & req_mask_i);
    end

endmodule

// File: rtl/l1d_miss_issue_scheduler.sv
// L1D miss-request scheduler: a pool of miss entries that merges requests to
// the same line, issues the oldest un-issued entry over a valid/ready port
// and retires entries on tagged refill responses.
module l1d_miss_issue_scheduler
    import l1d_sched_pkg::*;
#(
    parameter  int unsigned ENTRY_COUNT = ENTRY_COUNT_DEF,
    parameter  int unsigned LINE_ADDR_W = LINE_ADDR_W_DEF,
    localparam int unsigned TAG_W       = $clog2(ENTRY_COUNT)
) (
    input  logic                       clk,
    input  logic                       rst,
    l1d_miss_issue_scheduler_if.slave  bus
);

    miss_entry_t            entry_q [ENTRY_COUNT];
    miss_entry_t            entry_d [ENTRY_COUNT];

    logic [ENTRY_COUNT-1:0] wait_issue_mask;
    logic [ENTRY_COUNT-1:0] wait_resp_mask;
    logic [ENTRY_COUNT-1:0] busy_mask;
    logic [ENTRY_COUNT-1:0] resp_hit_mask;
    logic [ENTRY_COUNT-1:0] match_mask;
    logic [ENTRY_COUNT-1:0] issue_oh;
    logic [ENTRY_COUNT-1:0] flush_free_mask;
    logic [ENTRY_COUNT-1:0] free_mask;

    logic                   merge_hit;
    logic                   full;
    logic                   alloc_rdy;
    logic                   alloc_fire;
    logic                   issue_vld;
    logic                   issue_fire;

    logic [TAG_W-1:0]       merge_tag;
    logic [TAG_W-1:0]       free_idx;
    logic [TAG_W-1:0]       issue_tag;
    logic [LINE_ADDR_W-1:0] issue_addr;

    // Per-entry state decode, response hit and merge comparator.
    for (genvar gi = 0; gi < ENTRY_COUNT; gi++) begin : g_entry_decode
        assign wait_issue_mask[gi] = (entry_q[gi].state == WAIT_ISSUE);
        assign wait_resp_mask[gi]  = (entry_q[gi].state == WAIT_RESP);
        assign busy_mask[gi]       = (entry_q[gi].state != FREE);
        // Responses only count for entries actually waiting on one.
        assign resp_hit_mask[gi]   = bus.mem_resp_vld_i & wait_resp_mask[gi]
                                     & (bus.mem_resp_tag_i == TAG_W'(gi));
        // An entry retiring this cycle must not absorb a new request.
        assign match_mask[gi]      = busy_mask[gi] & ~resp_hit_mask[gi]
                                     & (entry_q[gi].addr == bus.alloc_addr_i);
    end

    assign merge_hit = bus.alloc_vld_i & (|match_mask);
    assign full      = &busy_mask;
    assign alloc_rdy = ~bus.flush_i & (merge_hit | ~full);
    assign alloc_fire = bus.alloc_vld_i & alloc_rdy & ~merge_hit;

    // Tag of the merge target; at most one entry can match.
    always_comb begin
        merge_tag = '0;
        for (int i = 0; i < ENTRY_COUNT; i++) begin
            if (match_mask[i]) begin
                merge_tag = merge_tag | TAG_W'(i);
            end
        end
    end

    // Lowest-indexed FREE entry by registered state (scan high to low, last hit wins).
    always_comb begin
        free_idx = '0;
        for (int i = ENTRY_COUNT - 1; i >= 0; i--) begin
            if (!busy_mask[i]) begin
                free_idx = TAG_W'(i);
            end
        end
    end

    // Oldest un-issued entry; later allocations are always younger, so the
    // selection holds steady until its handshake or a flush.
    l1d_miss_age_matrix #(
        .ENTRY_COUNT (ENTRY_COUNT)
    ) u_age_matrix (
        .clk         (clk),
        .rst         (rst),
        .alloc_en_i  (alloc_fire),
        .alloc_tag_i (free_idx),
        .busy_mask_i (busy_mask),
        .free_mask_i (free_mask),
        .req_mask_i  (wait_issue_mask),
        .oldest_oh_o (issue_oh)
    );

    assign issue_vld  = |wait_issue_mask;
    assign issue_fire = issue_vld & bus.mem_req_rdy_i;

    // A flush drops every un-issued entry except one handshaking this cycle.
    assign flush_free_mask = bus.flush_i ? (wait_issue_mask & ~(issue_fire ? issue_oh : '0)) : '0;
    assign free_mask       = resp_hit_mask | flush_free_mask;

    // Issue-port mux: OR-reduce the one-hot selected entry.
    always_comb begin
        issue_addr = '0;
        issue_tag  = '0;
        for (int i = 0; i < ENTRY_COUNT; i++) begin
            if (issue_oh[i]) begin
                issue_addr = issue_addr | entry_q[i].addr;
                issue_tag  = issue_tag | TAG_W'(i);
            end
        end
    end

    // Per-entry FSM: allocate, issue, retire, flush.
    always_comb begin
        for (int i = 0; i < ENTRY_COUNT; i++) begin
            entry_d[i] = entry_q[i];
            case (entry_q[i].state)
                FREE: begin
                    if (alloc_fire && (free_idx == TAG_W'(i))) begin
                        entry_d[i].state = WAIT_ISSUE;
                        entry_d[i].addr  = bus.alloc_addr_i;
                    end
                end
                WAIT_ISSUE: begin
                    if (issue_fire && issue_oh[i]) begin
                        entry_d[i].state = WAIT_RESP;
                    end else if (bus.flush_i) begin
                        entry_d[i].state = FREE;
                    end
                end
                WAIT_RESP: begin
                    if (resp_hit_mask[i]) begin
                        entry_d[i].state = FREE;
                    end
                end
                default: begin
                    entry_d[i].state = FREE;
                end
            endcase
        end
    end

    // Entry registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRY_COUNT; i++) begin
                entry_q[i] <= '{state: FREE, addr: '0};
            end
        end else begin
            for (int i = 0; i < ENTRY_COUNT; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    assign bus.alloc_rdy_o    = alloc_rdy;
    assign bus.alloc_merge_o  = merge_hit;
    assign bus.alloc_tag_o    = merge_hit ? merge_tag : free_idx;
    assign bus.mem_req_vld_o  = issue_vld;
    assign bus.mem_req_addr_o = issue_addr;
    assign bus.mem_req_tag_o  = issue_tag;
    assign bus.busy_mask_o    = busy_mask;
    assign bus.full_o         = full;
    assign bus.empty_o        = ~|busy_mask;

endmodule

// File: tb/tb_l1d_miss_issue_scheduler.sv
// Directed bench for l1d_miss_issue_scheduler: an 8-entry instance for the
// issue/merge/reset sequences and a 4-entry instance for full/flush cases.
// Stimulus pushes expected allocation and issue results into queues; monitor
// processes compare them whenever the DUT presents an allocation or request.
module tb_l1d_miss_issue_scheduler;

    typedef struct {
        logic rdy;
        logic merge;
        int   tag;
    } alloc_exp_t;

    typedef struct {
        logic [33:0] addr;
        int          tag;
    } req_exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alloc_exp_t q_alloc8[$];
    alloc_exp_t q_alloc4[$];
    req_exp_t   q_req8[$];
    req_exp_t   q_req4[$];

    l1d_miss_issue_scheduler_if #(.ENTRY_COUNT(8), .LINE_ADDR_W(34)) if8 ();
    l1d_miss_issue_scheduler_if #(.ENTRY_COUNT(4), .LINE_ADDR_W(34)) if4 ();

    l1d_miss_issue_scheduler #(.ENTRY_COUNT(8), .LINE_ADDR_W(34)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8.slave)
    );

    l1d_miss_issue_scheduler #(.ENTRY_COUNT(4), .LINE_ADDR_W(34)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv8(input logic vld, input logic [33:0] addr, input logic rdy,
                        input logic rvld, input int rtag, input logic fl);
        if8.alloc_vld_i    = vld;
        if8.alloc_addr_i   = addr;
        if8.mem_req_rdy_i  = rdy;
        if8.mem_resp_vld_i = rvld;
        if8.mem_resp_tag_i = 3'(rtag);
        if8.flush_i        = fl;
    endtask

    task automatic drv4(input logic vld, input logic [33:0] addr, input logic rdy,
                        input logic rvld, input int rtag, input logic fl);
        if4.alloc_vld_i    = vld;
        if4.alloc_addr_i   = addr;
        if4.mem_req_rdy_i  = rdy;
        if4.mem_resp_vld_i = rvld;
        if4.mem_resp_tag_i = 2'(rtag);
        if4.flush_i        = fl;
    endtask

    task automatic exp_alloc8(input logic rdy, input logic merge, input int tag);
        alloc_exp_t e;
        e.rdy = rdy; e.merge = merge; e.tag = tag;
        q_alloc8.push_back(e);
    endtask

    task automatic exp_alloc4(input logic rdy, input logic merge, input int tag);
        alloc_exp_t e;
        e.rdy = rdy; e.merge = merge; e.tag = tag;
        q_alloc4.push_back(e);
    endtask

    task automatic exp_req8(input logic [33:0] addr, input int tag);
        req_exp_t e;
        e.addr = addr; e.tag = tag;
        q_req8.push_back(e);
    endtask

    task automatic exp_req4(input logic [33:0] addr, input int tag);
        req_exp_t e;
        e.addr = addr; e.tag = tag;
        q_req4.push_back(e);
    endtask

    task automatic chk_reset(input string p, input logic vld, input logic rdy, input logic merge,
                             input logic [63:0] tag, input logic [63:0] rtag, input logic [63:0] raddr,
                             input logic [63:0] busy, input logic full, input logic empty);
        chk({p, "_reset_req_vld"}, vld, 0);
        chk({p, "_reset_alloc_rdy"}, rdy, 1);
        chk({p, "_reset_alloc_merge"}, merge, 0);
        chk({p, "_reset_alloc_tag"}, tag, 0);
        chk({p, "_reset_req_tag"}, rtag, 0);
        chk({p, "_reset_req_addr"}, raddr, 0);
        chk({p, "_reset_busy_mask"}, busy, 0);
        chk({p, "_reset_full"}, full, 0);
        chk({p, "_reset_empty"}, empty, 1);
    endtask

    // Monitor for the 8-entry instance.
    always @(negedge clk) begin
        alloc_exp_t ea;
        req_exp_t   er;
        if (rst) begin
            if (if8.alloc_vld_i) begin
                if (q_alloc8.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL e8_alloc_unexpected actual=presented required=none");
                end else begin
                    ea = q_alloc8.pop_front();
                    chk("e8_alloc_rdy", if8.alloc_rdy_o, ea.rdy);
                    if (ea.rdy) begin
                        chk("e8_alloc_merge", if8.alloc_merge_o, ea.merge);
                        chk("e8_alloc_tag", if8.alloc_tag_o, ea.tag);
                    end
                end
            end
            if (if8.mem_req_vld_o) begin
                if (q_req8.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL e8_req_unexpected actual=tag%0d addr=0x%0h required=no_request",
                             if8.mem_req_tag_o, if8.mem_req_addr_o);
                end else begin
                    er = q_req8[0];
                    chk("e8_req_addr", if8.mem_req_addr_o, er.addr);
                    chk("e8_req_tag", if8.mem_req_tag_o, er.tag);
                    if (if8.mem_req_rdy_i) begin
                        void'(q_req8.pop_front());
                    end
                end
            end
        end
    end

    // Monitor for the 4-entry instance.
    always @(negedge clk) begin
        alloc_exp_t ea;
        req_exp_t   er;
        if (rst) begin
            if (if4.alloc_vld_i) begin
                if (q_alloc4.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL e4_alloc_unexpected actual=presented required=none");
                end else begin
                    ea = q_alloc4.pop_front();
                    chk("e4_alloc_rdy", if4.alloc_rdy_o, ea.rdy);
                    if (ea.rdy) begin
                        chk("e4_alloc_merge", if4.alloc_merge_o, ea.merge);
                        chk("e4_alloc_tag", if4.alloc_tag_o, ea.tag);
                    end
                end
            end
            if (if4.mem_req_vld_o) begin
                if (q_req4.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL e4_req_unexpected actual=tag%0d addr=0x%0h required=no_request",
                             if4.mem_req_tag_o, if4.mem_req_addr_o);
                end else begin
                    er = q_req4[0];
                    chk("e4_req_addr", if4.mem_req_addr_o, er.addr);
                    chk("e4_req_tag", if4.mem_req_tag_o, er.tag);
                    if (if4.mem_req_rdy_i) begin
                        void'(q_req4.pop_front());
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        drv8(0, 0, 0, 0, 0, 0);
        drv4(0, 0, 0, 0, 0, 0);
        repeat (3) tick();

        // Reset values while held and after release
        chk_reset("e8_held", if8.mem_req_vld_o, if8.alloc_rdy_o, if8.alloc_merge_o, if8.alloc_tag_o,
                  if8.mem_req_tag_o, if8.mem_req_addr_o, if8.busy_mask_o, if8.full_o, if8.empty_o);
        chk_reset("e4_held", if4.mem_req_vld_o, if4.alloc_rdy_o, if4.alloc_merge_o, if4.alloc_tag_o,
                  if4.mem_req_tag_o, if4.mem_req_addr_o, if4.busy_mask_o, if4.full_o, if4.empty_o);
        rst = 1'b1;
        tick();
        chk_reset("e8_rel", if8.mem_req_vld_o, if8.alloc_rdy_o, if8.alloc_merge_o, if8.alloc_tag_o,
                  if8.mem_req_tag_o, if8.mem_req_addr_o, if8.busy_mask_o, if8.full_o, if8.empty_o);

        // ---- 8 entries: two allocations, stalled issue, back-to-back issue
        exp_alloc8(1, 0, 0); exp_req8(34'h100, 0);
        drv8(1, 34'h100, 0, 0, 0, 0);
        chk("e8_req_vld_before_alloc", if8.mem_req_vld_o, 0);
        tick();
        chk("e8_req_vld_latency", if8.mem_req_vld_o, 1);
        chk("e8_first_req_addr", if8.mem_req_addr_o, 34'h100);
        exp_alloc8(1, 0, 1); exp_req8(34'h200, 1);
        drv8(1, 34'h200, 0, 0, 0, 0);
        tick();
        drv8(0, 0, 0, 0, 0, 0);
        repeat (5) tick();
        drv8(0, 0, 1, 0, 0, 0);
        tick();
        tick();

        // Third line, issued, then merged into while waiting for its response
        exp_alloc8(1, 0, 2); exp_req8(34'h300, 2);
        drv8(1, 34'h300, 0, 0, 0, 0);
        tick();
        drv8(0, 0, 1, 0, 0, 0);
        tick();
        chk("e8_busy_before_merge", if8.busy_mask_o, 8'h07);
        exp_alloc8(1, 1, 2);
        drv8(1, 34'h300, 0, 0, 0, 0);
        tick();
        chk("e8_busy_after_merge", if8.busy_mask_o, 8'h07);

        // Same-line request while that line's entry retires: new entry, no merge
        exp_alloc8(1, 0, 3); exp_req8(34'h100, 3);
        drv8(1, 34'h100, 0, 1, 0, 0);
        tick();
        chk("e8_busy_resp_and_alloc", if8.busy_mask_o, 8'h0E);
        drv8(0, 0, 0, 0, 0, 0);
        tick();

        // Reset while a request is being presented
        chk("e8_req_vld_pre_reset", if8.mem_req_vld_o, 1);
        rst = 1'b0;
        #1;
        chk_reset("e8_mid", if8.mem_req_vld_o, if8.alloc_rdy_o, if8.alloc_merge_o, if8.alloc_tag_o,
                  if8.mem_req_tag_o, if8.mem_req_addr_o, if8.busy_mask_o, if8.full_o, if8.empty_o);
        q_req8.delete();
        tick();
        rst = 1'b1;
        repeat (3) begin
            tick();
            chk("e8_idle_after_reset", if8.mem_req_vld_o, 0);
        end
        exp_alloc8(1, 0, 0); exp_req8(34'h500, 0);
        drv8(1, 34'h500, 1, 0, 0, 0);
        tick();
        drv8(0, 0, 1, 0, 0, 0);
        tick();
        drv8(0, 0, 0, 0, 0, 0);
        tick();
        chk("e8_busy_after_reissue", if8.busy_mask_o, 8'h01);

        // ---- 4 entries: fill, reject, merge when full
        exp_alloc4(1, 0, 0); exp_req4(34'hA, 0);
        drv4(1, 34'hA, 0, 0, 0, 0); tick();
        exp_alloc4(1, 0, 1); exp_req4(34'hB, 1);
        drv4(1, 34'hB, 0, 0, 0, 0); tick();
        exp_alloc4(1, 0, 2); exp_req4(34'hC, 2);
        drv4(1, 34'hC, 0, 0, 0, 0); tick();
        exp_alloc4(1, 0, 3); exp_req4(34'hD, 3);
        drv4(1, 34'hD, 0, 0, 0, 0); tick();
        chk("e4_full_after_fill", if4.full_o, 1);
        chk("e4_busy_after_fill", if4.busy_mask_o, 4'hF);
        exp_alloc4(0, 0, 0);
        drv4(1, 34'hE, 0, 0, 0, 0); tick();
        exp_alloc4(1, 1, 1);
        drv4(1, 34'hB, 0, 0, 0, 0); tick();
        chk("e4_busy_after_merge", if4.busy_mask_o, 4'hF);

        // Issue tag 0, free it, allocate in the response cycle (rejected) and the next (accepted)
        drv4(0, 0, 1, 0, 0, 0); tick();
        exp_alloc4(0, 0, 0);
        drv4(1, 34'hE, 0, 1, 0, 0); tick();
        exp_alloc4(1, 0, 0); exp_req4(34'hE, 0);
        drv4(1, 34'hE, 0, 0, 0, 0); tick();
        chk("e4_full_after_realloc", if4.full_o, 1);

        // Issue all four: reallocated tag 0 must come out last
        drv4(0, 0, 1, 0, 0, 0);
        repeat (4) tick();
        chk("e4_no_req_after_drain", if4.mem_req_vld_o, 0);

        // Tags 0,1 waiting on responses, tags 2,3 not yet issued, then flush
        drv4(0, 0, 0, 1, 2, 0); tick();
        drv4(0, 0, 0, 1, 3, 0); tick();
        chk("e4_busy_after_resp", if4.busy_mask_o, 4'h3);
        exp_alloc4(1, 0, 2); exp_req4(34'hF, 2);
        drv4(1, 34'hF, 0, 0, 0, 0); tick();
        exp_alloc4(1, 0, 3); exp_req4(34'h10, 3);
        drv4(1, 34'h10, 0, 0, 0, 0); tick();
        exp_alloc4(0, 0, 0);
        drv4(1, 34'h11, 0, 0, 0, 0);
        if4.flush_i = 1'b1;
        tick();
        chk("e4_busy_after_flush", if4.busy_mask_o, 4'h3);
        chk("e4_req_vld_after_flush", if4.mem_req_vld_o, 0);
        chk("e4_flushed_req_count", q_req4.size(), 2);
        q_req4.delete();
        drv4(0, 0, 0, 1, 0, 0); tick();
        drv4(0, 0, 0, 1, 1, 0); tick();
        drv4(0, 0, 0, 0, 0, 0); tick();
        chk("e4_empty_at_end", if4.empty_o, 1);
        chk("e4_busy_at_end", if4.busy_mask_o, 4'h0);

        tick();
        chk("e8_alloc_queue_drained", q_alloc8.size(), 0);
        chk("e8_req_queue_drained", q_req8.size(), 0);
        chk("e4_alloc_queue_drained", q_alloc4.size(), 0);
        chk("e4_req_queue_drained", q_req4.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
